// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared helpers for the serial sequence detector family
package seq_det_pkg;
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (v == m) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/seq_match_counter.sv
// seq_match_counter: saturating match counter, clear has priority over increment
module seq_match_counter import seq_det_pkg::*; #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  logic [63:0] w_next;
  assign w_next = sat_inc(64'(count), CNT_W);
  assign sat = &count;
  // count matches, sticking at all ones until cleared
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= w_next[CNT_W-1:0];
endmodule

// File: rtl/param_seq_detector.sv
// param_seq_detector: programmable-length Mealy serial pattern detector with match counter
module param_seq_detector import seq_det_pkg::*; #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat
);
  localparam logic [LEN_W-1:0] AVAIL_MAX = LEN_W'(MAX_LEN - 1);
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_avail;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_active;
  logic               w_accept;
  logic               w_hit;
  assign w_window = {r_hist, din};
  assign w_active = (r_len != '0) && (int'(r_len) <= MAX_LEN);
  assign w_mask = {MAX_LEN{1'b1}} >> (MAX_LEN - int'(r_len));
  assign w_accept = din_valid & ~cfg_load;
  assign w_hit = w_active && (r_avail >= r_len - LEN_W'(1)) && (((w_window ^ r_pat) & w_mask) == '0);
  assign dout = w_accept & w_hit;
  // shadow configuration, captured only on cfg_load
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pat <= '0;
      r_len <= '0;
      r_ovl <= 1'b0;
    end else if (cfg_load) begin
      r_pat <= cfg_pattern;
      r_len <= cfg_len;
      r_ovl <= cfg_overlap;
    end
  // history and fill count; a non-overlapping match restarts the fill count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_hist  <= '0;
      r_avail <= '0;
    end else if (cfg_load) begin
      r_hist  <= '0;
      r_avail <= '0;
    end else if (din_valid) begin
      r_hist  <= w_window[MAX_LEN-2:0];
      r_avail <= (dout && !r_ovl) ? '0 : (r_avail == AVAIL_MAX) ? r_avail : r_avail + LEN_W'(1);
    end
  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(dout),
    .clr(cnt_clr),
    .count(match_count),
    .sat(cnt_sat)
  );
endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: directed checks of the sequence detector and its counter
module tb_param_seq_detector;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       dout, dout2;
  logic [7:0] match_count;
  logic [1:0] count2;
  logic       cnt_sat, sat2;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_seq_detector #(.MAX_LEN(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .dout(dout), .match_count(match_count), .cnt_sat(cnt_sat)
  );
  param_seq_detector #(.MAX_LEN(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .dout(dout2), .match_count(count2), .cnt_sat(sat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic exp, input string tag);
    @(negedge clk);
    din = d;
    din_valid = v;
    #1 chk(tag, 32'(dout), 32'(exp));
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    din = 1'b1;
    din_valid = 1'b1;
    cnt_clr = 1'b1;
    #1 chk("cfg_dout", 32'(dout), 32'd0);
    @(negedge clk);
    cfg_load = 1'b0;
    cnt_clr = 1'b0;
    din_valid = 1'b0;
    cfg_pattern = 8'hFF;
    cfg_len = 4'd2;
  endtask

  task automatic idle_chk_count(input logic [7:0] exp, input string tag);
    @(negedge clk);
    din_valid = 1'b0;
    #1 chk(tag, 32'(match_count), 32'(exp));
  endtask

  initial begin
    int exp_c[5];
    logic exp_s[5];
    exp_c = '{1, 2, 3, 3, 3};
    exp_s = '{0, 0, 1, 1, 1};
    #3;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_sat", 32'(cnt_sat), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, "nocfg_b1");
    step(1'b1, 1'b1, 1'b0, "nocfg_b2");
    step(1'b1, 1'b1, 1'b0, "nocfg_b3");
    step(1'b0, 1'b1, 1'b0, "nocfg_b4");
    // non-overlapping 0110 over 0110110
    cfg(8'b0110, 4'd4, 1'b0);
    step(0, 1, 0, "novl_b1"); step(1, 1, 0, "novl_b2"); step(1, 1, 0, "novl_b3");
    step(0, 1, 1, "novl_b4"); step(1, 1, 0, "novl_b5"); step(1, 1, 0, "novl_b6");
    step(0, 1, 0, "novl_b7");
    idle_chk_count(8'd1, "novl_count");
    // overlapping mode, same stream
    cfg(8'b0110, 4'd4, 1'b1);
    step(0, 1, 0, "ovl_b1"); step(1, 1, 0, "ovl_b2"); step(1, 1, 0, "ovl_b3");
    step(0, 1, 1, "ovl_b4"); step(1, 1, 0, "ovl_b5"); step(1, 1, 0, "ovl_b6");
    step(0, 1, 1, "ovl_b7");
    idle_chk_count(8'd2, "ovl_count");
    // a din_valid gap leaves history untouched
    cfg(8'b0110, 4'd4, 1'b0);
    step(0, 1, 0, "gap_b1"); step(1, 1, 0, "gap_b2"); step(0, 0, 0, "gap_idle");
    step(1, 1, 0, "gap_b3"); step(0, 1, 1, "gap_b4");
    idle_chk_count(8'd1, "gap_count");
    // reconfigure mid-stream: history is flushed by cfg_load
    step(1, 1, 0, "flush_pre1"); step(1, 1, 0, "flush_pre2");
    cfg(8'b110, 4'd3, 1'b0);
    step(0, 1, 0, "flush_b0"); step(1, 1, 0, "flush_b1"); step(1, 1, 0, "flush_b2");
    step(0, 1, 1, "flush_b3");
    idle_chk_count(8'd1, "flush_count");
    // length one, saturation of the 2-bit counter
    cfg(8'h01, 4'd1, 1'b0);
    step(0, 1, 0, "len1_zero");
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, "len1_one");
      @(posedge clk);
      #1;
      chk("sat_count", 32'(count2), 32'(exp_c[i]));
      chk("sat_flag", 32'(sat2), 32'(exp_s[i]));
    end
    @(negedge clk);
    din = 1'b1;
    din_valid = 1'b1;
    cnt_clr = 1'b1;
    #1 chk("clr_dout", 32'(dout2), 32'd1);
    @(posedge clk);
    #1;
    chk("clr_count2", 32'(count2), 32'd0);
    chk("clr_sat2", 32'(sat2), 32'd0);
    chk("clr_count", 32'(match_count), 32'd0);
    cnt_clr = 1'b0;
    // asynchronous reset mid-stream wipes configuration too
    cfg(8'b0110, 4'd4, 1'b0);
    step(0, 1, 0, "pre_rst_b1"); step(1, 1, 0, "pre_rst_b2"); step(1, 1, 0, "pre_rst_b3");
    step(0, 1, 1, "pre_rst_b4");
    step(0, 1, 0, "pre_rst_b5"); step(1, 1, 0, "pre_rst_b6");
    idle_chk_count(8'd1, "pre_rst_count");
    step(1, 1, 0, "mid_b3");
    @(negedge clk);
    din = 1'b0;
    din_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_count", 32'(match_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, "post_rst_b1"); step(1, 1, 0, "post_rst_b2"); step(1, 1, 0, "post_rst_b3");
    step(0, 1, 0, "post_rst_b4");
    idle_chk_count(8'd0, "post_rst_count");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
